// File: rtl/trig_fire_if.sv
// Trigger record readout bus between trig_fire_scheduler (slave) and the slow-side reader (master).
// Handshake: rd_valid is high whenever the FIFO is non-empty and rd_id/rd_ts/rd_mask show the head
// entry; the head is consumed at a clk_adc edge where rd_en and rd_valid are both high, and rd_en
// while rd_valid is low is ignored.
interface trig_fire_if #(
  parameter int NTRIG      = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_W       = 56
);
  localparam int IDW = $clog2(NTRIG);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  logic              rd_en;
  logic              rd_valid;
  logic [IDW-1:0]    rd_id;
  logic [TS_W-1:0]   rd_ts;
  logic [NTRIG-1:0]  rd_mask;
  logic [CW-1:0]     fifo_count;
  logic [15:0]       overflow_cnt;

  modport master (
    output rd_en,
    input  rd_valid, rd_id, rd_ts, rd_mask, fifo_count, overflow_cnt
  );

  modport slave (
    input  rd_en,
    output rd_valid, rd_id, rd_ts, rd_mask, fifo_count, overflow_cnt
  );
endinterface

// File: rtl/trig_fire_scheduler.sv
// Round-robin trigger fire scheduler with global dead time and a timestamped grant record FIFO.
// Optional macro TRIG_PILEUP_MASK_EN stores the eligible vector per record and presents it on rd_mask.
module trig_fire_scheduler #(
  parameter int NTRIG      = 8,
  parameter int NOUT       = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_W       = 56
) (
  input  logic                      clk_adc,
  input  logic                      reset,
  input  logic [NTRIG-1:0]          trig_req,
  input  logic [NTRIG-1:0]          trig_enable,
  input  logic                      busy,
  input  logic                      pass_prescale,
  input  logic [NTRIG*NOUT-1:0]     out_map,
  input  logic [7:0]                out_width,
  input  logic [7:0]                dead_time,
  input  logic                      ts_clear,
  output logic [NOUT-1:0]           coax_out,
  output logic                      fired,
  output logic [$clog2(NTRIG)-1:0]  fired_id,
  output logic [TS_W-1:0]           timestamp,
  output logic [1:0]                state_dbg,
  trig_fire_if.slave                rd
);
  localparam int IDW = $clog2(NTRIG);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FIRE = 2'd1, S_DEAD = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [NTRIG-1:0] elig;
  logic [IDW-1:0]   rr_ptr, win, idx;
  logic             found, grant;
  logic [7:0]       cnt, dead_lat;

  assign elig      = trig_req & trig_enable;
  assign state_dbg = state;

  // First eligible requester at or above rr_ptr, wrapping.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NTRIG; i++) begin
      idx = rr_ptr + IDW'(i);
      if (!found && elig[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      S_IDLE: if (found && !busy && pass_prescale) begin
        grant     = 1'b1;
        state_nxt = S_FIRE;
      end
      S_FIRE: if (cnt == 8'd0) state_nxt = (dead_lat == 8'd0) ? S_IDLE : S_DEAD;
      S_DEAD: if (cnt == 8'd0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_adc) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // cnt holds remaining cycles of the current phase minus one; coax_out doubles as the latched map.
  always_ff @(posedge clk_adc) begin
    if (reset) begin
      cnt      <= '0;
      dead_lat <= '0;
      coax_out <= '0;
      fired    <= 1'b0;
      fired_id <= '0;
      rr_ptr   <= '0;
    end else begin
      fired <= grant;
      case (state)
        S_IDLE: if (grant) begin
          fired_id <= win;
          rr_ptr   <= win + IDW'(1);
          coax_out <= out_map[win*NOUT +: NOUT];
          cnt      <= (out_width == 8'd0) ? 8'd0 : out_width - 8'd1;
          dead_lat <= dead_time;
        end
        S_FIRE: if (cnt == 8'd0) begin
          coax_out <= '0;
          cnt      <= (dead_lat == 8'd0) ? 8'd0 : dead_lat - 8'd1;
        end else begin
          cnt <= cnt - 8'd1;
        end
        S_DEAD: if (cnt != 8'd0) cnt <= cnt - 8'd1;
        default: cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk_adc) begin
    if (reset || ts_clear) timestamp <= '0;
    else                   timestamp <= timestamp + TS_W'(1);
  end

  logic [IDW-1:0]  id_mem [FIFO_DEPTH];
  logic [TS_W-1:0] ts_mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [CW-1:0]   count;
  logic [15:0]     ovf;
  logic            fifo_full, push, pop, drop;

  assign fifo_full = (count == CW'(FIFO_DEPTH));
  assign pop       = rd.rd_en && (count != '0);
  // A pop in the same cycle frees the slot, so a grant into a full FIFO is still accepted then.
  assign push      = grant && (!fifo_full || pop);
  assign drop      = grant && fifo_full && !pop;

  always_ff @(posedge clk_adc) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        id_mem[i] <= '0;
        ts_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        id_mem[wptr] <= win;
        ts_mem[wptr] <= timestamp;
        wptr         <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop && ovf != 16'hFFFF) ovf <= ovf + 16'd1;
    end
  end

`ifdef TRIG_PILEUP_MASK_EN
  logic [NTRIG-1:0] mask_mem [FIFO_DEPTH];

  always_ff @(posedge clk_adc) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mask_mem[i] <= '0;
    end else if (push) begin
      mask_mem[wptr] <= elig;
    end
  end

  assign rd.rd_mask = mask_mem[rptr];
`else
  assign rd.rd_mask = '0;
`endif

  assign rd.rd_valid     = (count != '0);
  assign rd.rd_id        = id_mem[rptr];
  assign rd.rd_ts        = ts_mem[rptr];
  assign rd.fifo_count   = count;
  assign rd.overflow_cnt = ovf;
endmodule

// File: tb/tb_trig_fire_scheduler.sv
// Directed self-checking bench for trig_fire_scheduler: arbitration, pulse timing, dead time,
// vetoes, record FIFO order/overflow, reset during a fire and timestamp clear.
module tb_trig_fire_scheduler;
  localparam int NTRIG = 8;
  localparam int NOUT  = 16;
  localparam int FD    = 8;
  localparam int TS_W  = 56;
  localparam int IDW   = 3;
  localparam int EW    = NTRIG + IDW + TS_W;

  logic                  clk_adc = 1'b0;
  logic                  reset;
  logic [NTRIG-1:0]      trig_req, trig_enable;
  logic                  busy, pass_prescale, ts_clear;
  logic [NTRIG*NOUT-1:0] out_map;
  logic [7:0]            out_width, dead_time;
  logic [NOUT-1:0]       coax_out;
  logic                  fired;
  logic [IDW-1:0]        fired_id;
  logic [TS_W-1:0]       timestamp;
  logic [1:0]            state_dbg;

  trig_fire_if #(.NTRIG(NTRIG), .FIFO_DEPTH(FD), .TS_W(TS_W)) rd_if ();

  trig_fire_scheduler #(.NTRIG(NTRIG), .NOUT(NOUT), .FIFO_DEPTH(FD), .TS_W(TS_W)) dut (
    .clk_adc(clk_adc), .reset(reset), .trig_req(trig_req), .trig_enable(trig_enable),
    .busy(busy), .pass_prescale(pass_prescale), .out_map(out_map), .out_width(out_width),
    .dead_time(dead_time), .ts_clear(ts_clear), .coax_out(coax_out), .fired(fired),
    .fired_id(fired_id), .timestamp(timestamp), .state_dbg(state_dbg), .rd(rd_if)
  );

  // clock / reset
  always #5 clk_adc = ~clk_adc;

  int n_checks = 0;
  int n_errors = 0;
  logic [TS_W-1:0] exp_ts = '0;
  logic [EW-1:0]   exp_q[$];
  int ids5[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; exp_ts tracks the free-running counter from the driven reset/clear.
  task automatic tick();
    @(posedge clk_adc);
    if (reset || ts_clear) exp_ts = '0;
    else                   exp_ts = exp_ts + 1'b1;
    #1;
  endtask

  function automatic logic [NTRIG-1:0] mask_exp(input logic [NTRIG-1:0] e);
`ifdef TRIG_PILEUP_MASK_EN
    return e;
`else
    return '0;
`endif
  endfunction

  task automatic push_exp(input logic [NTRIG-1:0] e, input int id);
    exp_q.push_back({mask_exp(e), IDW'(id), exp_ts});
  endtask

  task automatic pop_check(input string tag);
    logic [EW-1:0] ent;
    ent = exp_q.pop_front();
    check({tag, "_valid"}, 64'(rd_if.rd_valid), 64'd1);
    check({tag, "_id"},    64'(rd_if.rd_id),    64'(ent[TS_W +: IDW]));
    check({tag, "_ts"},    64'(rd_if.rd_ts),    64'(ent[TS_W-1:0]));
    check({tag, "_mask"},  64'(rd_if.rd_mask),  64'(ent[TS_W+IDW +: NTRIG]));
    rd_if.rd_en = 1'b1;
    tick();
    rd_if.rd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; trig_req = '0; trig_enable = 8'hFF; busy = 1'b0; pass_prescale = 1'b1;
    ts_clear = 1'b0; out_width = 8'd3; dead_time = 8'd5; rd_if.rd_en = 1'b0;
    for (int k = 0; k < NTRIG; k++)
      out_map[k*NOUT +: NOUT] = (k == 2) ? 16'h0100 : (16'h0001 << k);

    tick(); tick();
    check("rst_coax",  64'(coax_out), 64'h0);
    check("rst_fired", 64'(fired), 64'h0);
    check("rst_ts",    64'(timestamp), 64'h0);
    check("rst_cnt",   64'(rd_if.fifo_count), 64'h0);
    check("rst_valid", 64'(rd_if.rd_valid), 64'h0);
    check("rst_ovf",   64'(rd_if.overflow_cnt), 64'h0);
    check("rst_state", 64'(state_dbg), 64'h0);

    // single pulse on trigger 2
    reset = 1'b0; trig_req = 8'h04;
    push_exp(8'h04, 2);
    tick();
    trig_req = 8'h00;
    check("t1_fired", 64'(fired), 64'h1);
    check("t1_id",    64'(fired_id), 64'h2);
    check("t1_coax1", 64'(coax_out), 64'h0100);
    check("t1_state", 64'(state_dbg), 64'h1);
    check("t1_ts",    64'(timestamp), 64'(exp_ts));
    tick();
    check("t1_fired_once", 64'(fired), 64'h0);
    check("t1_coax2", 64'(coax_out), 64'h0100);
    tick();
    check("t1_coax3", 64'(coax_out), 64'h0100);
    tick();
    check("t1_coax_off", 64'(coax_out), 64'h0);
    check("t1_dead", 64'(state_dbg), 64'h2);
    check("t1_count", 64'(rd_if.fifo_count), 64'h1);
    pop_check("t1_rec");
    check("t1_empty", 64'(rd_if.rd_valid), 64'h0);
    for (int i = 0; i < 4; i++) tick();
    check("t1_idle", 64'(state_dbg), 64'h0);

    // held request: one grant every 3+5+1 cycles
    trig_req = 8'h04;
    for (int c = 1; c <= 27; c++) begin
      if ((c - 1) % 9 == 0) push_exp(8'h04, 2);
      tick();
      check("t2_fired", 64'(fired), 64'((c - 1) % 9 == 0));
      check("t2_coax",  64'(coax_out), ((c - 1) % 9 < 3) ? 64'h0100 : 64'h0);
      check("t2_count", 64'(rd_if.fifo_count), 64'((c - 1) / 9 + 1));
    end
    trig_req = 8'h00;
    for (int i = 0; i < 3; i++) pop_check("t2_rec");

    // round robin between 0 and 7 from a fresh pointer
    reset = 1'b1; tick(); reset = 1'b0;
    out_width = 8'd1; dead_time = 8'd0; trig_req = 8'h81;
    for (int c = 1; c <= 8; c++) begin
      if (c % 2 == 1) push_exp(8'h81, (c % 4 == 1) ? 0 : 7);
      tick();
      check("t3_fired", 64'(fired), 64'(c % 2));
      if (c % 2 == 1) check("t3_id", 64'(fired_id), (c % 4 == 1) ? 64'd0 : 64'd7);
      check("t3_coax", 64'(coax_out), (c % 2 == 0) ? 64'h0 : ((c % 4 == 1) ? 64'h0001 : 64'h0080));
    end
    trig_req = 8'h00;
    check("t3_count", 64'(rd_if.fifo_count), 64'd4);
    for (int i = 0; i < 4; i++) pop_check("t3_rec");

    // busy and prescale vetoes
    out_width = 8'd2; dead_time = 8'd1; trig_req = 8'h10; busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_busy_fired", 64'(fired), 64'h0);
      check("t4_busy_coax",  64'(coax_out), 64'h0);
      check("t4_busy_cnt",   64'(rd_if.fifo_count), 64'h0);
    end
    busy = 1'b0; pass_prescale = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_ps_fired", 64'(fired), 64'h0);
      check("t4_ps_cnt",   64'(rd_if.fifo_count), 64'h0);
    end
    pass_prescale = 1'b1;
    push_exp(8'h10, 4);
    tick();
    trig_req = 8'h00;
    check("t4_fired", 64'(fired), 64'h1);
    check("t4_id",    64'(fired_id), 64'd4);
    check("t4_coax",  64'(coax_out), 64'h0010);
    for (int i = 0; i < 3; i++) tick();
    pop_check("t4_rec");

    // ten grants into an eight-deep FIFO
    out_width = 8'd1; dead_time = 8'd0; trig_req = 8'h0F;
    for (int c = 1; c <= 20; c++) begin
      if (c % 2 == 1 && (c - 1) / 2 < 8) push_exp(8'h0F, ids5[(c - 1) / 2]);
      tick();
    end
    trig_req = 8'h00;
    check("t5_count", 64'(rd_if.fifo_count), 64'd8);
    check("t5_ovf",   64'(rd_if.overflow_cnt), 64'd2);
    for (int i = 0; i < 8; i++) pop_check("t5_rec");
    check("t5_empty", 64'(rd_if.rd_valid), 64'h0);
    check("t5_count0", 64'(rd_if.fifo_count), 64'd0);

    // reset in the middle of a fire with three records queued
    out_width = 8'd4; dead_time = 8'd0; trig_req = 8'h02;
    for (int c = 1; c <= 11; c++) tick();
    trig_req = 8'h00;
    check("t6_pre_state", 64'(state_dbg), 64'h1);
    check("t6_pre_coax",  64'(coax_out), 64'h0002);
    check("t6_pre_count", 64'(rd_if.fifo_count), 64'd3);
    check("t6_pre_ovf",   64'(rd_if.overflow_cnt), 64'd2);
    reset = 1'b1;
    tick();
    check("t6_coax",  64'(coax_out), 64'h0);
    check("t6_count", 64'(rd_if.fifo_count), 64'd0);
    check("t6_ts",    64'(timestamp), 64'd0);
    check("t6_ovf",   64'(rd_if.overflow_cnt), 64'd0);
    check("t6_state", 64'(state_dbg), 64'h0);
    check("t6_valid", 64'(rd_if.rd_valid), 64'h0);

    // timestamp clear
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("ts_run", 64'(timestamp), 64'(exp_ts));
    check("ts_run_val", 64'(timestamp), 64'd5);
    ts_clear = 1'b1;
    tick();
    ts_clear = 1'b0;
    check("ts_clear", 64'(timestamp), 64'd0);
    tick();
    check("ts_after_clear", 64'(timestamp), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
